// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus words, RAM status codes and the memory arbiter state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter, bundled as one interface.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      mem_err;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    // Caches and RAM model side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between icache and dcache: dcache priority with an
// icache starvation guard, request-withdrawal abort, error and timeout detection.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

    arb_state_t          state, state_next;
    logic [STREAK_W-1:0] streak, streak_next;
    logic [CNT_W-1:0]    tcnt, tcnt_next;
    logic                err_q, err_set;
    logic                grant_stall;
    logic                streak_full;

    assign streak_full = (streak == STREAK_W'(MAX_D_STREAK));
    assign bus.iload   = bus.ramload;
    assign bus.dload   = bus.ramload;
    assign bus.mem_err = err_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            streak <= '0;
            tcnt   <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
            tcnt   <= tcnt_next;
            err_q  <= err_q | err_set;
        end
    end

    always_comb begin
        state_next   = state;
        streak_next  = bus.iREN ? streak : '0;
        tcnt_next    = tcnt;
        err_set      = 1'b0;
        grant_stall  = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;

        case (state)
            IDLE: begin
                tcnt_next = '0;
                if (bus.iREN && streak_full)       state_next = IGNT;
                else if (bus.dREN || bus.dWEN)     state_next = DGNT;
                else if (bus.iREN)                 state_next = IGNT;
            end
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    state_next = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait   = 1'b0;
                        streak_next = '0;
                        state_next  = IDLE;
                    end else begin
                        grant_stall = 1'b1;
                    end
                end
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!bus.dREN && !bus.dWEN) begin
                    state_next = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dwait  = 1'b0;
                    state_next = IDLE;
                    if (bus.iREN && !streak_full) streak_next = streak + STREAK_W'(1);
                end else begin
                    grant_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A live grant without ACCESS either fails now or keeps counting toward timeout
        if (grant_stall) begin
            if (bus.ramstate == ERROR || tcnt == CNT_W'(TIMEOUT - 1)) begin
                err_set    = 1'b1;
                state_next = IDLE;
            end else begin
                tcnt_next = tcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation guard, error, reset, timeout.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(64), .CNT_W(7)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        #1;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.mem_err} !== 5'b00110) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00110",
                            {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.mem_err});
        end
        total++;
        if ({bus.ramaddr, bus.ramstore} !== 64'h0) begin
            bad++; $display("FAIL reset_bus got=%h want=0", {bus.ramaddr, bus.ramstore});
        end
    endtask

    task automatic test_fetch();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        #1;
        total++;
        if ({bus.ramREN, bus.iwait} !== 2'b01) begin
            bad++; $display("FAIL fetch_c1 got=%b want=01", {bus.ramREN, bus.iwait});
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            bus.ramstate = BUSY;
            #1;
            total++;
            if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.ramaddr} !== {3'b101, 32'h40}) begin
                bad++; $display("FAIL fetch_busy%0d got=%b/%h want=101/00000040", c,
                                {bus.ramREN, bus.ramWEN, bus.iwait}, bus.ramaddr);
            end
        end
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        #1;
        total++;
        if ({bus.iwait, bus.dwait, bus.iload} !== {2'b01, 32'hDEADBEEF}) begin
            bad++; $display("FAIL fetch_access got=%b/%h want=01/deadbeef",
                            {bus.iwait, bus.dwait}, bus.iload);
        end
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        #1;
        total++;
        if (dut.state !== IDLE || bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
            bad++; $display("FAIL fetch_done state=%0d ramREN=%b iwait=%b want=0/0/1",
                            dut.state, bus.ramREN, bus.iwait);
        end
    endtask

    task automatic test_priority();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        tick();
        bus.ramstate = ACCESS;
        #1;
        total++;
        if ({bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait, bus.ramaddr, bus.ramstore}
            !== {4'b1001, 32'h80, 32'h1234}) begin
            bad++; $display("FAIL prio_dgnt got=%b/%h/%h want=1001/00000080/00001234",
                            {bus.ramWEN, bus.ramREN, bus.dwait, bus.iwait},
                            bus.ramaddr, bus.ramstore);
        end
        tick();
        bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
        #1;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
            bad++; $display("FAIL prio_bubble got=%b want=0011",
                            {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait});
        end
        tick();
        bus.ramstate = ACCESS;
        #1;
        total++;
        if ({bus.ramREN, bus.iwait, bus.dwait, bus.ramaddr} !== {3'b101, 32'h44}) begin
            bad++; $display("FAIL prio_ignt got=%b/%h want=101/00000044",
                            {bus.ramREN, bus.iwait, bus.dwait}, bus.ramaddr);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [5:0] seq;
        int         n;
        seq = '0; n = 0;
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = ACCESS;
        for (int c = 0; c < 30 && n < 6; c++) begin
            #1;
            if (!bus.iwait) begin seq[5-n] = 1'b1; n++; end
            else if (!bus.dwait) begin seq[5-n] = 1'b0; n++; end
            tick();
        end
        total++;
        if (n != 6) begin
            bad++; $display("FAIL starve_budget completions=%0d want=6", n);
        end
        total++;
        if (seq !== 6'b000010) begin
            bad++; $display("FAIL starve_order got=%b want=000010 (1=icache)", seq);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_error();
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        tick();
        bus.ramstate = ERROR;
        #1;
        total++;
        if ({bus.dwait, bus.mem_err} !== 2'b10) begin
            bad++; $display("FAIL err_cycle got=%b want=10", {bus.dwait, bus.mem_err});
        end
        tick();
        bus.ramstate = FREE;
        #1;
        total++;
        if (bus.mem_err !== 1'b1 || dut.state !== IDLE || bus.dwait !== 1'b1) begin
            bad++; $display("FAIL err_set mem_err=%b state=%0d dwait=%b want=1/0/1",
                            bus.mem_err, dut.state, bus.dwait);
        end
        tick();
        bus.ramstate = ACCESS;
        #1;
        total++;
        if (bus.dwait !== 1'b0) begin
            bad++; $display("FAIL err_retry dwait=%b want=0", bus.dwait);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (bus.mem_err !== 1'b1) begin
            bad++; $display("FAIL err_sticky mem_err=%b want=1", bus.mem_err);
        end
    endtask

    task automatic test_reset_mid();
        bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h55;
        tick();
        bus.ramstate = BUSY;
        #1;
        total++;
        if (bus.ramWEN !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre ramWEN=%b want=1", bus.ramWEN);
        end
        nRST = 1'b0;
        tick();
        #1;
        total++;
        if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.mem_err} !== 5'b00110) begin
            bad++; $display("FAIL rst_mid got=%b want=00110",
                            {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.mem_err});
        end
        idle_inputs();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int  n;
        logic pulsed;
        n = 0; pulsed = 1'b0;
        bus.iREN = 1'b1; bus.iaddr = 32'h300; bus.ramstate = BUSY;
        tick();
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.mem_err) break;
            if (!bus.iwait) pulsed = 1'b1;
            tick();
            n++;
        end
        total++;
        if (n != 64) begin
            bad++; $display("FAIL timeout_cycles got=%0d want=64", n);
        end
        total++;
        if (pulsed !== 1'b0 || bus.mem_err !== 1'b1) begin
            bad++; $display("FAIL timeout_flags iwait_pulse=%b mem_err=%b want=0/1",
                            pulsed, bus.mem_err);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_error();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
